// File: rtl/div_pkg.sv
// Shared definitions for the sequential radix-2 restoring divider:
// FSM state encoding and the counter-width helper.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ZERO = 2'd2,
        ST_FIN  = 2'd3
    } div_state_e;

    // Number of bits needed to count 0..value-1; never less than one.
    function automatic int clog2(input int value);
        int bits;
        bits = 1;
        while ((32'sd1 << bits) < value) begin
            bits = bits + 1;
        end
        return bits;
    endfunction

endpackage : div_pkg

// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bus of seq_divider.
// Optional macro DIV_SIGNED_EN adds the is_signed request field.
interface seq_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
`ifdef DIV_SIGNED_EN
    logic             is_signed;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

`ifdef DIV_SIGNED_EN
    modport master (
        output start, dividend, divisor, is_signed,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, dividend, divisor, is_signed,
        output busy, done, quotient, remainder, div_by_zero
    );
`else
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );
    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
`endif

endinterface : seq_divider_if

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem,q} left,
// subtract the divisor when it fits and shift the resulting bit into q.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_rem_in,
    input  logic [WIDTH-1:0] i_q_in,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem_out,
    output logic [WIDTH-1:0] o_q_out
);

    logic [WIDTH:0] w_shift;
    logic           w_fits;

    assign w_shift   = {i_rem_in, i_q_in[WIDTH-1]};
    assign w_fits    = (w_shift >= {1'b0, i_divisor});
    // When the trial subtraction fits, the difference is below the divisor and needs only WIDTH bits.
    assign o_rem_out = w_fits ? (w_shift[WIDTH-1:0] - i_divisor) : w_shift[WIDTH-1:0];
    assign o_q_out   = {i_q_in[WIDTH-2:0], w_fits};

endmodule : div_step

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per clock.
// Optional macro DIV_SIGNED_EN enables two's-complement operation via is_signed.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  io_div
);

    localparam int CW = clog2(WIDTH);

    div_state_e       r_state;
    div_state_e       w_next_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_dividend;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_div_by_zero;

    logic             w_accept;
    logic             w_last;
    logic             w_busy;
    logic             w_done;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_q_fixed;
    logic [WIDTH-1:0] w_r_fixed;

    assign w_accept = io_div.start && ((r_state == ST_IDLE) || (r_state == ST_FIN));
    assign w_last   = (r_state == ST_RUN) && (r_count == CW'(WIDTH - 1));

`ifdef DIV_SIGNED_EN
    assign w_a_neg = io_div.is_signed & io_div.dividend[WIDTH-1];
    assign w_b_neg = io_div.is_signed & io_div.divisor[WIDTH-1];
`else
    assign w_a_neg = 1'b0;
    assign w_b_neg = 1'b0;
`endif

    // MIN has no positive counterpart, but its negation read as unsigned is the right magnitude.
    assign w_a_mag   = w_a_neg ? (~io_div.dividend + WIDTH'(1)) : io_div.dividend;
    assign w_b_mag   = w_b_neg ? (~io_div.divisor + WIDTH'(1))  : io_div.divisor;
    assign w_q_fixed = r_neg_q ? (~w_q_next + WIDTH'(1))   : w_q_next;
    assign w_r_fixed = r_neg_r ? (~w_rem_next + WIDTH'(1)) : w_rem_next;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem_in  (r_rem),
        .i_q_in    (r_q),
        .i_divisor (r_divisor),
        .o_rem_out (w_rem_next),
        .o_q_out   (w_q_next)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; FIN behaves like IDLE for a new request.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE, ST_FIN: begin
                if (w_accept) begin
                    w_next_state = (io_div.divisor == {WIDTH{1'b0}}) ? ST_ZERO : ST_RUN;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next_state = ST_FIN;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_ZERO: w_next_state = ST_FIN;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_RUN, ST_ZERO: w_busy = 1'b1;
            ST_FIN:          w_done = 1'b1;
            default: begin
                w_busy = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    // Operand capture and per-cycle iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= {CW{1'b0}};
            r_rem      <= {WIDTH{1'b0}};
            r_q        <= {WIDTH{1'b0}};
            r_divisor  <= {WIDTH{1'b0}};
            r_dividend <= {WIDTH{1'b0}};
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
        end else if (w_accept) begin
            r_count    <= {CW{1'b0}};
            r_rem      <= {WIDTH{1'b0}};
            r_q        <= w_a_mag;
            r_divisor  <= w_b_mag;
            r_dividend <= io_div.dividend;
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
        end else if (r_state == ST_RUN) begin
            r_rem   <= w_rem_next;
            r_q     <= w_q_next;
            r_count <= w_last ? r_count : (r_count + CW'(1));
        end
    end

    // Result registers, written only on the edge that enters FIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quotient    <= {WIDTH{1'b0}};
            r_remainder   <= {WIDTH{1'b0}};
            r_div_by_zero <= 1'b0;
        end else if (w_last) begin
            r_quotient    <= w_q_fixed;
            r_remainder   <= w_r_fixed;
            r_div_by_zero <= 1'b0;
        end else if (r_state == ST_ZERO) begin
            r_quotient    <= {WIDTH{1'b1}};
            r_remainder   <= r_dividend;
            r_div_by_zero <= 1'b1;
        end
    end

    assign io_div.busy        = w_busy;
    assign io_div.done        = w_done;
    assign io_div.quotient    = r_quotient;
    assign io_div.remainder   = r_remainder;
    assign io_div.div_by_zero = r_div_by_zero;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=8) against an arithmetic reference model.
module tb_seq_divider;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_div (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain arithmetic on the operands; latency in edges after the start edge.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                         output logic [7:0] q, output logic [7:0] r, output logic z, output int lat);
        int sa;
        int sb;
        if (b == 8'd0) begin
            q = 8'hFF; r = a; z = 1'b1; lat = 1;
        end else if (sgn) begin
            sa = $signed(a);
            sb = $signed(b);
            z = 1'b0; lat = W;
            if (sa == -128 && sb == -1) begin
                q = 8'h80; r = 8'h00;
            end else begin
                q = 8'(sa / sb);
                r = 8'(sa % sb);
            end
        end else begin
            q = a / b; r = a % b; z = 1'b0; lat = W;
        end
    endtask

    // Issue one request and wait (bounded) for done; returns observations.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sgn,
                          output int lat, output logic [7:0] q, output logic [7:0] r,
                          output logic z, output logic busy0, output logic done_after);
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
`ifdef DIV_SIGNED_EN
        bus.is_signed = sgn;
`endif
        @(negedge clk);
        bus.start = 1'b0;
        bus.dividend = 8'($urandom); bus.divisor = 8'($urandom);
`ifdef DIV_SIGNED_EN
        bus.is_signed = 1'b0;
`endif
        busy0 = bus.busy;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        q = bus.quotient; r = bus.remainder; z = bus.div_by_zero;
        @(negedge clk);
        done_after = bus.done;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.quotient !== 8'd0) begin errors++; $display("FAIL reset_q got=%0d exp=0", bus.quotient); end
        checks++; if (bus.remainder !== 8'd0) begin errors++; $display("FAIL reset_r got=%0d exp=0", bus.remainder); end
        checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", bus.div_by_zero); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat; logic [7:0] q, r; logic z, b0, d1;
        run_op(8'd200, 8'd7, 1'b0, lat, q, r, z, b0, d1);
        checks++; if (lat !== 8) begin errors++; $display("FAIL basic_lat got=%0d exp=8", lat); end
        checks++; if (q !== 8'd28) begin errors++; $display("FAIL basic_q got=%0d exp=28", q); end
        checks++; if (r !== 8'd4) begin errors++; $display("FAIL basic_r got=%0d exp=4", r); end
        checks++; if (z !== 1'b0) begin errors++; $display("FAIL basic_dbz got=%b exp=0", z); end
        checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", b0); end
        checks++; if (d1 !== 1'b0) begin errors++; $display("FAIL basic_pulse got=%b exp=0", d1); end
        checks++; if (bus.quotient !== 8'd28) begin errors++; $display("FAIL basic_hold got=%0d exp=28", bus.quotient); end
    endtask

    task automatic test_zero();
        int lat; logic [7:0] q, r; logic z, b0, d1;
        run_op(8'd5, 8'd0, 1'b0, lat, q, r, z, b0, d1);
        checks++; if (lat !== 1) begin errors++; $display("FAIL zero_lat got=%0d exp=1", lat); end
        checks++; if (q !== 8'hFF) begin errors++; $display("FAIL zero_q got=%0h exp=ff", q); end
        checks++; if (r !== 8'd5) begin errors++; $display("FAIL zero_r got=%0d exp=5", r); end
        checks++; if (z !== 1'b1) begin errors++; $display("FAIL zero_dbz got=%b exp=1", z); end
        checks++; if (d1 !== 1'b0) begin errors++; $display("FAIL zero_pulse got=%b exp=0", d1); end
    endtask

    task automatic test_back_to_back();
        int lat1; int lat2;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd7; bus.divisor = 8'd9;
        @(negedge clk);
        bus.start = 1'b0;
        lat1 = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done) begin lat1 = k; break; end
        end
        checks++; if (lat1 !== 8) begin errors++; $display("FAIL b2b_lat1 got=%0d exp=8", lat1); end
        checks++; if (bus.quotient !== 8'd0) begin errors++; $display("FAIL b2b_q1 got=%0d exp=0", bus.quotient); end
        checks++; if (bus.remainder !== 8'd7) begin errors++; $display("FAIL b2b_r1 got=%0d exp=7", bus.remainder); end
        bus.start = 1'b1; bus.dividend = 8'd255; bus.divisor = 8'd1;
        @(negedge clk);
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy got=%b exp=1", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_pulse got=%b exp=0", bus.done); end
        lat2 = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done) begin lat2 = k; break; end
        end
        checks++; if (lat2 !== 8) begin errors++; $display("FAIL b2b_lat2 got=%0d exp=8", lat2); end
        checks++; if (bus.quotient !== 8'd255) begin errors++; $display("FAIL b2b_q2 got=%0d exp=255", bus.quotient); end
        checks++; if (bus.remainder !== 8'd0) begin errors++; $display("FAIL b2b_r2 got=%0d exp=0", bus.remainder); end
        @(negedge clk);
    endtask

    task automatic test_ignore_busy();
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 8'd7;
        @(negedge clk);
        bus.start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            if (k == 4) begin bus.start = 1'b1; bus.dividend = 8'd50; bus.divisor = 8'd3; end
            else begin bus.start = 1'b0; end
            @(negedge clk);
            if (bus.done) begin lat = k; break; end
        end
        bus.start = 1'b0;
        checks++; if (lat !== 8) begin errors++; $display("FAIL ign_lat got=%0d exp=8", lat); end
        checks++; if (bus.quotient !== 8'd14) begin errors++; $display("FAIL ign_q got=%0d exp=14", bus.quotient); end
        checks++; if (bus.remainder !== 8'd2) begin errors++; $display("FAIL ign_r got=%0d exp=2", bus.remainder); end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL ign_idle got=%b exp=0", bus.busy); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [7:0] q, r; logic z, b0, d1;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd200; bus.divisor = 8'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rmid_done got=%b exp=0", bus.done); end
        checks++; if (bus.quotient !== 8'd0) begin errors++; $display("FAIL rmid_q got=%0d exp=0", bus.quotient); end
        checks++; if (bus.remainder !== 8'd0) begin errors++; $display("FAIL rmid_r got=%0d exp=0", bus.remainder); end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'd100, 8'd10, 1'b0, lat, q, r, z, b0, d1);
        checks++; if (lat !== 8) begin errors++; $display("FAIL rmid_lat got=%0d exp=8", lat); end
        checks++; if (q !== 8'd10) begin errors++; $display("FAIL rmid_q2 got=%0d exp=10", q); end
        checks++; if (r !== 8'd0) begin errors++; $display("FAIL rmid_r2 got=%0d exp=0", r); end
    endtask

    task automatic test_random(input logic sgn);
        int lat; int elat; logic [7:0] a, b, q, r, eq, er; logic z, ez, b0, d1;
        for (int i = 0; i < 30; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            if (i == 0) begin a = 8'hFF; b = 8'hFF; end
            model(a, b, sgn, eq, er, ez, elat);
            run_op(a, b, sgn, lat, q, r, z, b0, d1);
            checks++; if (q !== eq) begin errors++; $display("FAIL rand_q a=%0h b=%0h s=%b got=%0h exp=%0h", a, b, sgn, q, eq); end
            checks++; if (r !== er) begin errors++; $display("FAIL rand_r a=%0h b=%0h s=%b got=%0h exp=%0h", a, b, sgn, r, er); end
            checks++; if (z !== ez) begin errors++; $display("FAIL rand_dbz a=%0h b=%0h got=%b exp=%b", a, b, z, ez); end
            checks++; if (lat !== elat) begin errors++; $display("FAIL rand_lat a=%0h b=%0h got=%0d exp=%0d", a, b, lat, elat); end
        end
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed();
        int lat; logic [7:0] q, r; logic z, b0, d1;
        run_op(8'hF9, 8'h02, 1'b1, lat, q, r, z, b0, d1);
        checks++; if (q !== 8'hFD) begin errors++; $display("FAIL sgn_q got=%0h exp=fd", q); end
        checks++; if (r !== 8'hFF) begin errors++; $display("FAIL sgn_r got=%0h exp=ff", r); end
        run_op(8'h80, 8'hFF, 1'b1, lat, q, r, z, b0, d1);
        checks++; if (q !== 8'h80) begin errors++; $display("FAIL sgn_ovf_q got=%0h exp=80", q); end
        checks++; if (r !== 8'h00) begin errors++; $display("FAIL sgn_ovf_r got=%0h exp=0", r); end
        checks++; if (z !== 1'b0) begin errors++; $display("FAIL sgn_ovf_dbz got=%b exp=0", z); end
        checks++; if (lat !== 8) begin errors++; $display("FAIL sgn_ovf_lat got=%0d exp=8", lat); end
        test_random(1'b1);
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        bus.start = 1'b0;
        bus.dividend = 8'd0;
        bus.divisor = 8'd0;
`ifdef DIV_SIGNED_EN
        bus.is_signed = 1'b0;
`endif
        test_reset();
        test_basic();
        test_zero();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        test_random(1'b0);
`ifdef DIV_SIGNED_EN
        test_signed();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seq_divider
